lcd_spi_scanout_m: RTL and testbench

//  Read side of the PPU's LCD framebuffer. The PPU writes 2-bit shades via lcd_addr/lcd_write.

---
 rtl/lcd_defs_pkg.sv | 28 ++
 rtl/spi_shift_tx_m.sv | 52 +++++
 rtl/lcd_spi_scanout_m.sv | 141 ++++++++++++++
 tb/tb_lcd_spi_scanout_m.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_defs_pkg.sv
// Shared LCD definitions: scan-out FSM states, pixel word type, panel geometry and
// the panel's memory-write command, plus the shade-to-RGB565 palette lookup.
package lcd_defs;

  typedef enum logic [1:0] {IDLE, CMD, PIX, DONE} lcd_scan_state_e;

  typedef logic [15:0] rgb565_t;

  localparam int         LCD_W     = 160;
  localparam int         LCD_H     = 144;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  function automatic rgb565_t shade_to_rgb(input logic [1:0] shade,
                                           input rgb565_t    s0,
                                           input rgb565_t    s1,
                                           input rgb565_t    s2,
                                           input rgb565_t    s3);
    rgb565_t word;
    case (shade)
      2'd0:    word = s0;
      2'd1:    word = s1;
      2'd2:    word = s2;
      default: word = s3;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/spi_shift_tx_m.sv
// SPI mode-0 transmitter, MSB first, two clocks per bit. A load always wins, so the
// next word can be loaded during the last bit's high phase with no sclk gap.
module spi_shift_tx_m (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [4:0]  nbits,
  output logic        sclk,
  output logic        mosi,
  output logic        last_bit
);

  logic [15:0] shreg;
  logic [3:0]  bits_left;
  logic        active;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bits_left <= '0;
      active    <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else if (load) begin
      shreg     <= data;
      bits_left <= 4'(nbits - 5'd1);
      active    <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= data[15];
    end else if (active) begin
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (bits_left == 4'd0) begin
          // Word finished with nothing queued: park the line low.
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          shreg     <= {shreg[14:0], 1'b0};
          mosi      <= shreg[14];
          bits_left <= bits_left - 4'd1;
        end
      end
    end
  end

  // High during the sclk-high phase of the final bit of the current word.
  assign last_bit = active && sclk && (bits_left == 4'd0);

endmodule

// File: rtl/lcd_spi_scanout_m.sv
// Framebuffer scan-out: on frame_start, sends RAMWR then every pixel as RGB565 over SPI,
// prefetching each pixel's shade one pixel ahead. Handshake: frame_start is a 1-cycle request, frame_done a 1-cycle completion.
module lcd_spi_scanout_m #(
  parameter int          FB_WIDTH  = lcd_defs::LCD_W,
  parameter int          FB_HEIGHT = lcd_defs::LCD_H,
  parameter logic [15:0] SHADE0    = 16'hFFFF,
  parameter logic [15:0] SHADE1    = 16'hAD55,
  parameter logic [15:0] SHADE2    = 16'h52AA,
  parameter logic [15:0] SHADE3    = 16'h0000,
  parameter logic [7:0]  CMD_RAMWR = lcd_defs::CMD_RAMWR
) (
  input  logic                      clk_4mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic                      fb_rd_en,
  output logic [14:0]               fb_addr,
  input  logic [1:0]                fb_rd_data,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  output logic                      spi_cs_n,
  output logic                      spi_dc,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_overrun,
  output lcd_defs::lcd_scan_state_e scan_state
);

  import lcd_defs::*;

  localparam int          N_PIX = FB_WIDTH * FB_HEIGHT;
  localparam logic [14:0] LAST  = 15'(N_PIX - 1);

  lcd_scan_state_e state;
  logic [14:0]     pix_idx;
  logic [1:0]      next_px;
  logic            rd_pending;
  logic            load;
  logic [15:0]     load_data;
  logic [4:0]      load_nbits;
  logic            last_bit;

  always_comb begin
    load       = 1'b0;
    load_data  = shade_to_rgb(next_px, SHADE0, SHADE1, SHADE2, SHADE3);
    load_nbits = 5'd16;
    if ((state == IDLE || state == DONE) && frame_start) begin
      load       = 1'b1;
      load_data  = {CMD_RAMWR, 8'h00};
      load_nbits = 5'd8;
    end else if (state == CMD && last_bit) begin
      load = 1'b1;
    end else if (state == PIX && last_bit && pix_idx != LAST) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      state         <= IDLE;
      spi_cs_n      <= 1'b1;
      spi_dc        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      fb_rd_en      <= 1'b0;
      fb_addr       <= '0;
      pix_idx       <= '0;
      next_px       <= '0;
      rd_pending    <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      fb_rd_en      <= 1'b0;
      rd_pending    <= fb_rd_en;
      // Read data trails fb_rd_en by one cycle.
      if (rd_pending) next_px <= fb_rd_data;
      case (state)
        IDLE, DONE: begin
          // A start landing on the frame_done cycle is taken straight away.
          if (frame_start) begin
            state    <= CMD;
            spi_cs_n <= 1'b0;
            spi_dc   <= 1'b0;
            busy     <= 1'b1;
            fb_rd_en <= 1'b1;
            fb_addr  <= '0;
            pix_idx  <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CMD: begin
          if (frame_start) frame_overrun <= 1'b1;
          if (last_bit) begin
            state   <= PIX;
            spi_dc  <= 1'b1;
            pix_idx <= '0;
            if (LAST != 15'd0) begin
              fb_rd_en <= 1'b1;
              fb_addr  <= 15'd1;
            end
          end
        end
        PIX: begin
          if (frame_start) frame_overrun <= 1'b1;
          if (last_bit) begin
            if (pix_idx == LAST) begin
              state      <= DONE;
              spi_cs_n   <= 1'b1;
              spi_dc     <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              pix_idx <= pix_idx + 15'd1;
              // The final pixel was already fetched; no read past the frame.
              if (pix_idx + 15'd1 != LAST) begin
                fb_rd_en <= 1'b1;
                fb_addr  <= pix_idx + 15'd2;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_shift_tx_m u_tx (
    .clk      (clk_4mhz),
    .rst      (rst),
    .load     (load),
    .data     (load_data),
    .nbits    (load_nbits),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi),
    .last_bit (last_bit)
  );

  assign scan_state = state;

endmodule

// File: tb/tb_lcd_spi_scanout_m.sv
// Bench for lcd_spi_scanout_m on a 4x2 framebuffer: the expected SPI bit stream is
// built from the frame contents and palette, then compared with what the panel would see.
`timescale 1ns/1ps
module tb_lcd_spi_scanout_m;

  localparam int W         = 4;
  localparam int H         = 2;
  localparam int N         = W * H;
  localparam int AW        = $clog2(N);
  localparam int FRAME_CYC = 1 + 16 + 32 * N;
  localparam int BUDGET    = 4 * FRAME_CYC;

  logic        clk_4mhz = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        fb_rd_en;
  logic [14:0] fb_addr;
  logic [1:0]  fb_rd_data = 2'd0;
  logic        spi_sclk, spi_mosi, spi_cs_n, spi_dc;
  logic        busy, frame_done, frame_overrun;
  lcd_defs::lcd_scan_state_e scan_state;

  lcd_spi_scanout_m #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk_4mhz      (clk_4mhz),
    .rst           (rst),
    .frame_start   (frame_start),
    .fb_rd_en      (fb_rd_en),
    .fb_addr       (fb_addr),
    .fb_rd_data    (fb_rd_data),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_cs_n      (spi_cs_n),
    .spi_dc        (spi_dc),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .scan_state    (scan_state)
  );

  // Clock and reset
  always #125 clk_4mhz = ~clk_4mhz;

  logic [1:0]  mem [N];
  logic [1:0]  exp_q[$];
  logic [1:0]  cap_q[$];
  logic [14:0] rd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          overrun_cnt = 0;
  int          stray_rd = 0;
  int          sclk_rises = 0;

  // Framebuffer model with a one-cycle read latency, plus bus monitors.
  always @(posedge clk_4mhz) begin
    if (fb_rd_en) begin
      fb_rd_data <= mem[fb_addr[AW-1:0]];
      rd_q.push_back(fb_addr);
    end
    if (fb_rd_en && spi_cs_n) stray_rd++;
    if (frame_overrun) overrun_cnt++;
  end

  always @(posedge spi_sclk) begin
    cap_q.push_back({spi_dc, spi_mosi});
    sclk_rises++;
  end

  // Reference model
  function automatic logic [15:0] ref_rgb(input logic [1:0] s);
    case (s)
      2'd0:    return 16'hFFFF;
      2'd1:    return 16'hAD55;
      2'd2:    return 16'h52AA;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic build_expected();
    logic [7:0]  cmd;
    logic [15:0] word;
    cmd = 8'h2C;
    exp_q.delete();
    for (int b = 7; b >= 0; b--) exp_q.push_back({1'b0, cmd[b]});
    for (int i = 0; i < N; i++) begin
      word = ref_rgb(mem[i]);
      for (int b = 15; b >= 0; b--) exp_q.push_back({1'b1, word[b]});
    end
  endtask

  function automatic int first_bit_err();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= cap_q.size()) return i;
      if (cap_q[i] !== exp_q[i]) return i;
    end
    if (cap_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic int first_rd_err();
    for (int i = 0; i < N; i++) begin
      if (i >= rd_q.size()) return i;
      if (rd_q[i] !== 15'(i)) return i;
    end
    if (rd_q.size() != N) return N;
    return -1;
  endfunction

  // Drivers
  task automatic clear_sb();
    cap_q.delete();
    rd_q.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic pulse_start();
    @(negedge clk_4mhz);
    frame_start = 1'b1;
    @(negedge clk_4mhz);
    frame_start = 1'b0;
  endtask

  // Entered at the negedge of the first cycle after the accepted start (lat = 1).
  task automatic wait_done(input int inject_at, output int lat, output int busy_gap);
    lat = 1;
    busy_gap = 0;
    while (frame_done !== 1'b1 && lat < BUDGET) begin
      if (busy !== 1'b1) busy_gap++;
      frame_start = (lat == inject_at);
      @(negedge clk_4mhz);
      lat++;
    end
    frame_start = 1'b0;
    if (lat >= BUDGET) begin
      $display("FAIL frame_done_timeout: waited %0d cycles, limit %0d", lat, BUDGET);
      n_bad++;
      n_cmp++;
    end
  endtask

  // Tests
  task automatic test_reset();
    int rises0;
    rst = 1'b1;
    repeat (3) @(negedge clk_4mhz);
    n_cmp++;
    if ({spi_cs_n, spi_sclk, spi_mosi, spi_dc} !== 4'b1000) begin
      $display("FAIL reset_spi: cs_n/sclk/mosi/dc got %b want 1000",
               {spi_cs_n, spi_sclk, spi_mosi, spi_dc});
      n_bad++;
    end
    n_cmp++;
    if ({busy, frame_done, frame_overrun, fb_rd_en} !== 4'b0000) begin
      $display("FAIL reset_status: busy/done/overrun/rd_en got %b want 0000",
               {busy, frame_done, frame_overrun, fb_rd_en});
      n_bad++;
    end
    n_cmp++;
    if (fb_addr !== 15'd0) begin
      $display("FAIL reset_addr: got %0d want 0", fb_addr);
      n_bad++;
    end
    rst = 1'b0;
    rises0 = sclk_rises;
    repeat (100) @(negedge clk_4mhz);
    n_cmp++;
    if (sclk_rises - rises0 !== 0 || spi_cs_n !== 1'b1) begin
      $display("FAIL idle_quiet: sclk rises %0d cs_n %b want 0 rises cs_n 1",
               sclk_rises - rises0, spi_cs_n);
      n_bad++;
    end
  endtask

  task automatic test_small_frame();
    int lat, gap, e;
    mem = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    build_expected();
    clear_sb();
    pulse_start();
    wait_done(-1, lat, gap);
    n_cmp++;
    if (lat !== FRAME_CYC) begin
      $display("FAIL small_latency: got %0d want %0d", lat, FRAME_CYC);
      n_bad++;
    end
    e = first_bit_err();
    n_cmp++;
    if (e !== -1) begin
      $display("FAIL small_bits: first bad bit %0d, got %0d bits want %0d", e, cap_q.size(), exp_q.size());
      n_bad++;
    end
    e = first_rd_err();
    n_cmp++;
    if (e !== -1) begin
      $display("FAIL small_reads: first bad read %0d, got %0d reads want %0d", e, rd_q.size(), N);
      n_bad++;
    end
    n_cmp++;
    if (gap !== 0) begin
      $display("FAIL small_busy: busy low %0d cycles mid-frame want 0", gap);
      n_bad++;
    end
    @(negedge clk_4mhz);
    n_cmp++;
    if ({busy, spi_cs_n, spi_sclk} !== 3'b010) begin
      $display("FAIL small_after_done: busy/cs_n/sclk got %b want 010", {busy, spi_cs_n, spi_sclk});
      n_bad++;
    end
  endtask

  task automatic test_random_frames();
    int lat, gap, e;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      build_expected();
      clear_sb();
      pulse_start();
      wait_done(-1, lat, gap);
      e = first_bit_err();
      n_cmp++;
      if (e !== -1 || lat !== FRAME_CYC) begin
        $display("FAIL rand%0d_frame: first bad bit %0d latency %0d, want bit -1 latency %0d",
                 f, e, lat, FRAME_CYC);
        n_bad++;
      end
      e = first_rd_err();
      n_cmp++;
      if (e !== -1) begin
        $display("FAIL rand%0d_reads: first bad read %0d got %0d reads want %0d", f, e, rd_q.size(), N);
        n_bad++;
      end
      repeat ($urandom_range(1, 5)) @(negedge clk_4mhz);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap, e, ovr0;
    fill_random();
    build_expected();
    clear_sb();
    ovr0 = overrun_cnt;
    pulse_start();
    wait_done(-1, lat, gap);
    e = first_bit_err();
    n_cmp++;
    if (e !== -1 || lat !== FRAME_CYC) begin
      $display("FAIL b2b_first: first bad bit %0d latency %0d want -1 and %0d", e, lat, FRAME_CYC);
      n_bad++;
    end
    // Request the next frame during the frame_done cycle itself.
    frame_start = 1'b1;
    clear_sb();
    @(negedge clk_4mhz);
    frame_start = 1'b0;
    n_cmp++;
    if ({busy, spi_cs_n, fb_rd_en, spi_dc} !== 4'b1010 || fb_addr !== 15'd0) begin
      $display("FAIL b2b_restart: busy/cs_n/rd_en/dc got %b addr %0d want 1010 addr 0",
               {busy, spi_cs_n, fb_rd_en, spi_dc}, fb_addr);
      n_bad++;
    end
    wait_done(-1, lat, gap);
    e = first_bit_err();
    n_cmp++;
    if (e !== -1 || lat !== FRAME_CYC) begin
      $display("FAIL b2b_second: first bad bit %0d latency %0d want -1 and %0d", e, lat, FRAME_CYC);
      n_bad++;
    end
    e = first_rd_err();
    n_cmp++;
    if (e !== -1 || overrun_cnt - ovr0 !== 0) begin
      $display("FAIL b2b_reads: first bad read %0d overruns %0d want -1 and 0", e, overrun_cnt - ovr0);
      n_bad++;
    end
  endtask

  task automatic test_overrun();
    int lat, gap, e, ovr0;
    mem = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    build_expected();
    clear_sb();
    repeat (3) @(negedge clk_4mhz);
    ovr0 = overrun_cnt;
    pulse_start();
    wait_done(50, lat, gap);
    n_cmp++;
    if (overrun_cnt - ovr0 !== 1) begin
      $display("FAIL overrun_pulse: got %0d pulses want 1", overrun_cnt - ovr0);
      n_bad++;
    end
    e = first_bit_err();
    n_cmp++;
    if (e !== -1 || lat !== FRAME_CYC) begin
      $display("FAIL overrun_stream: first bad bit %0d latency %0d want -1 and %0d", e, lat, FRAME_CYC);
      n_bad++;
    end
  endtask

  task automatic test_rst_mid_frame();
    int lat, gap, e;
    fill_random();
    clear_sb();
    pulse_start();
    // Cycle 120 after the start falls inside pixel 3 (pixel 3 spans 113..144).
    for (int i = 1; i < 120; i++) @(negedge clk_4mhz);
    rst = 1'b1;
    @(negedge clk_4mhz);
    rst = 1'b0;
    n_cmp++;
    if ({spi_cs_n, busy, spi_sclk, fb_rd_en} !== 4'b1000 || scan_state !== lcd_defs::IDLE) begin
      $display("FAIL rst_mid: cs_n/busy/sclk/rd_en got %b state %0d want 1000 state 0",
               {spi_cs_n, busy, spi_sclk, fb_rd_en}, scan_state);
      n_bad++;
    end
    fill_random();
    build_expected();
    clear_sb();
    pulse_start();
    wait_done(-1, lat, gap);
    e = first_bit_err();
    n_cmp++;
    if (e !== -1 || lat !== FRAME_CYC) begin
      $display("FAIL rst_restart_bits: first bad bit %0d latency %0d want -1 and %0d", e, lat, FRAME_CYC);
      n_bad++;
    end
    e = first_rd_err();
    n_cmp++;
    if (e !== -1) begin
      $display("FAIL rst_restart_reads: first bad read %0d got %0d reads want %0d", e, rd_q.size(), N);
      n_bad++;
    end
  endtask

  task automatic test_read_gating();
    repeat (4) @(negedge clk_4mhz);
    n_cmp++;
    if (stray_rd !== 0) begin
      $display("FAIL rd_gating: %0d reads with cs_n high want 0", stray_rd);
      n_bad++;
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_small_frame();
    test_random_frames();
    test_back_to_back();
    test_overrun();
    test_rst_mid_frame();
    test_read_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
